dbus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the data bus between the RV32 core (`dbus_if_core0`) and the debug module's system-bus access port (`dbus_if_dm0`). It sits in front of `dbus_interconnect` and presents a single master port to it. The debug module normally has priority, limited by a starvation guard for the running core. A per-transaction watchdog terminates transfers that the addressed slave never completes.

---
 rtl/dbus_arbiter.sv | 145 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data bus between the RV32 core and the debug
// module's system-bus port. The debug module wins by default, bounded by a
// starvation guard for a running core; a watchdog closes transfers that the
// addressed slave never completes.
module dbus_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int MAX_DM_STREAK  = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_halted,
   input  logic          c_bstart,
   input  logic [AW-1:0] c_addr,
   input  logic          c_ttype,
   input  logic [1:0]    c_tsize,
   input  logic [DW-1:0] c_wdata,
   output logic          c_bdone,
   output logic          c_berr,
   output logic [DW-1:0] c_rdata,
   input  logic          d_bstart,
   input  logic [AW-1:0] d_addr,
   input  logic          d_ttype,
   input  logic [1:0]    d_tsize,
   input  logic [DW-1:0] d_wdata,
   output logic          d_bdone,
   output logic          d_berr,
   output logic [DW-1:0] d_rdata,
   output logic          s_bstart,
   output logic [AW-1:0] s_addr,
   output logic          s_ttype,
   output logic [1:0]    s_tsize,
   output logic [DW-1:0] s_wdata,
   input  logic          s_bdone,
   input  logic [DW-1:0] s_rdata,
   output logic [1:0]    grant
);

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [3:0]      STREAK_MAX = 4'(MAX_DM_STREAK);
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_C = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      streak;
   logic [WD_W-1:0] wd;
   logic            granted;
   logic            timeout;
   logic            done;

   assign granted = (state != IDLE);
   // The watchdog fires only when the slave stays silent in the last allowed
   // cycle; a completion in that same cycle wins and is reported as normal.
   assign timeout = granted && (wd == WD_LAST) && !s_bdone;
   assign done    = granted && (s_bdone || timeout);

   // State register: the grant is held until completion or watchdog expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: arbitrate only from IDLE, never re-grant mid-transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (c_bstart && d_bstart)
               state_nxt = (core_halted || (streak != STREAK_MAX)) ? GNT_D : GNT_C;
            else if (d_bstart)
               state_nxt = GNT_D;
            else if (c_bstart)
               state_nxt = GNT_C;
         end
         GNT_C, GNT_D: begin
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Starvation guard: counts DM wins over a running, waiting core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak <= '0;
      end else if (state == IDLE) begin
         if (!c_bstart)
            streak <= '0;
         else if (state_nxt == GNT_C)
            streak <= '0;
         else if ((state_nxt == GNT_D) && !core_halted && (streak != STREAK_MAX))
            streak <= streak + 4'd1;
      end
   end

   // Watchdog: counts open cycles of the current grant, zero outside a grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   wd <= '0;
      else if (!granted || done) wd <= '0;
      else                       wd <= wd + WD_W'(1);
   end

   // Outputs: request mux on the registered grant, completion steered back.
   always_comb begin
      s_bstart = 1'b0;
      s_addr   = c_addr;
      s_ttype  = c_ttype;
      s_tsize  = c_tsize;
      s_wdata  = c_wdata;
      c_bdone  = 1'b0;
      c_berr   = 1'b0;
      c_rdata  = '0;
      d_bdone  = 1'b0;
      d_berr   = 1'b0;
      d_rdata  = '0;
      grant    = {state == GNT_D, state == GNT_C};
      case (state)
         GNT_C: begin
            s_bstart = c_bstart && !timeout;
            c_bdone  = s_bdone || timeout;
            c_berr   = timeout;
            c_rdata  = s_bdone ? s_rdata : '0;
         end
         GNT_D: begin
            s_bstart = d_bstart && !timeout;
            s_addr   = d_addr;
            s_ttype  = d_ttype;
            s_tsize  = d_tsize;
            s_wdata  = d_wdata;
            d_bdone  = s_bdone || timeout;
            d_berr   = timeout;
            d_rdata  = s_bdone ? s_rdata : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter (MAX_DM_STREAK=4, TIMEOUT_CYCLES=8).
module tb_dbus_arbiter;

   localparam int MAXS = 4;
   localparam int TO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_halted;
   logic        c_bstart, d_bstart;
   logic [31:0] c_addr, d_addr;
   logic        c_ttype, d_ttype;
   logic [1:0]  c_tsize, d_tsize;
   logic [31:0] c_wdata, d_wdata;
   logic        c_bdone, d_bdone, c_berr, d_berr;
   logic [31:0] c_rdata, d_rdata;
   logic        s_bstart;
   logic [31:0] s_addr;
   logic        s_ttype;
   logic [1:0]  s_tsize;
   logic [31:0] s_wdata;
   logic        s_bdone;
   logic [31:0] s_rdata;
   logic [1:0]  grant;

   int errors = 0;
   int checks = 0;

   dbus_arbiter #(.AW(32), .DW(32), .MAX_DM_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .core_halted(core_halted),
      .c_bstart(c_bstart), .c_addr(c_addr), .c_ttype(c_ttype), .c_tsize(c_tsize),
      .c_wdata(c_wdata), .c_bdone(c_bdone), .c_berr(c_berr), .c_rdata(c_rdata),
      .d_bstart(d_bstart), .d_addr(d_addr), .d_ttype(d_ttype), .d_tsize(d_tsize),
      .d_wdata(d_wdata), .d_bdone(d_bdone), .d_berr(d_berr), .d_rdata(d_rdata),
      .s_bstart(s_bstart), .s_addr(s_addr), .s_ttype(s_ttype), .s_tsize(s_tsize),
      .s_wdata(s_wdata), .s_bdone(s_bdone), .s_rdata(s_rdata), .grant(grant)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Directed cycle table: inputs for one cycle and outputs expected in it.
   typedef struct packed {
      logic       cb, db, hl, sb;
      logic [1:0] g;
      logic       sbs, cd, dd;
   } vec_t;
   vec_t tbl [10];

   logic [1:0] gseq [16];
   int         gcnt;

   // Lets both masters request continuously with a zero-wait slave and
   // records the order in which grants are handed out.
   task automatic collect(input int n);
      gcnt = 0;
      for (int cyc = 0; cyc < 60 && gcnt < n; cyc++) begin
         step();
         s_bdone = (grant != 2'b00);
         #1;
         if (grant != 2'b00) begin
            gseq[gcnt] = grant;
            gcnt++;
         end
      end
   endtask

   // Reference model state
   int          m_owner, m_streak, m_wd, nxt;
   logic        cp, dp, to_e;
   logic        e_cd, e_dd, e_ce, e_de, e_sbs;
   logic [1:0]  e_g;
   logic [31:0] e_cr, e_dr;

   initial begin
      rst = 1'b1; core_halted = 1'b0;
      c_bstart = 1'b0; d_bstart = 1'b0;
      c_addr = 32'h1000_0004; d_addr = 32'h2000_0000;
      c_ttype = 1'b0; d_ttype = 1'b0; c_tsize = 2'd2; d_tsize = 2'd2;
      c_wdata = 32'h0; d_wdata = 32'h0;
      s_bdone = 1'b1; s_rdata = 32'hFFFF_FFFF;

      // ---------------- reset state ----------------
      step(); step();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_ctl", 64'({s_bstart, c_bdone, c_berr, d_bdone, d_berr}), 64'd0);
      chk("rst_rdata", {c_rdata, d_rdata}, 64'd0);
      rst = 1'b0; s_bdone = 1'b0;

      // ---------------- table: priority, completion, late bdone, violation ----------------
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         c_bstart = tbl[i].cb; d_bstart = tbl[i].db; core_halted = tbl[i].hl;
         s_bdone = tbl[i].sb; s_rdata = 32'h1234_5600 + 32'(i);
         #1;
         chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].g));
         chk($sformatf("tbl%0d_ctl", i), 64'({s_bstart, c_bdone, d_bdone, c_berr, d_berr}),
             64'({tbl[i].sbs, tbl[i].cd, tbl[i].dd, 2'b00}));
         chk($sformatf("tbl%0d_rdata", i), {c_rdata, d_rdata},
             {tbl[i].cd ? s_rdata : 32'h0, tbl[i].dd ? s_rdata : 32'h0});
         chk($sformatf("tbl%0d_addr", i), 64'(s_addr),
             64'((tbl[i].g == 2'b10) ? d_addr : c_addr));
         step();
      end

      // ---------------- core only: WRITE WORD, slave completes after 3 cycles ----------------
      c_bstart = 1'b1; c_ttype = 1'b1; c_tsize = 2'd2;
      c_addr = 32'h1000_0004; c_wdata = 32'hDEAD_BEEF; s_bdone = 1'b0;
      #1 chk("core_idle_grant", 64'(grant), 64'd0);
      for (int k = 1; k <= 3; k++) begin
         step();
         s_bdone = (k == 3);
         #1;
         chk($sformatf("core_c%0d_grant", k), 64'(grant), 64'b01);
         chk($sformatf("core_c%0d_req", k), {s_bstart, s_ttype, s_tsize, s_wdata, s_addr[27:0]},
             {1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 28'h000_0004});
         chk($sformatf("core_c%0d_done", k), 64'({c_bdone, c_berr, d_bdone}), 64'({k == 3, 2'b00}));
      end
      step();
      c_bstart = 1'b0; s_bdone = 1'b0;
      #1 chk("core_after_grant", 64'(grant), 64'd0);

      // ---------------- starvation guard ----------------
      c_bstart = 1'b1; d_bstart = 1'b1; core_halted = 1'b0;
      c_ttype = 1'b0; d_ttype = 1'b0;
      collect(10);
      chk("starve_count", 64'(gcnt), 64'd10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve_g%0d", i), 64'(gseq[i]), 64'((i % 5 == 4) ? 2'b01 : 2'b10));

      // ---------------- halted core: DM always wins ----------------
      core_halted = 1'b1;
      collect(6);
      chk("halt_count", 64'(gcnt), 64'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("halt_g%0d", i), 64'(gseq[i]), 64'b10);
      step();
      d_bstart = 1'b0; s_bdone = 1'b0;
      step();
      s_bdone = 1'b1;
      #1;
      chk("halt_core_grant", 64'(grant), 64'b01);
      chk("halt_core_done", 64'({c_bdone, d_bdone}), 64'b10);
      step();
      c_bstart = 1'b0; s_bdone = 1'b0; core_halted = 1'b0;

      // ---------------- watchdog timeout and late bdone ----------------
      d_bstart = 1'b1; s_rdata = 32'hA5A5_0001;
      for (int k = 1; k <= TO; k++) begin
         step();
         #1;
         chk($sformatf("to_c%0d_grant", k), 64'(grant), 64'b10);
         chk($sformatf("to_c%0d_ctl", k), 64'({s_bstart, d_bdone, d_berr, c_bdone}),
             64'({k != TO, k == TO, k == TO, 1'b0}));
         chk($sformatf("to_c%0d_rdata", k), 64'(d_rdata), 64'd0);
      end
      step();
      d_bstart = 1'b0; s_bdone = 1'b1;
      #1;
      chk("late_grant", 64'(grant), 64'd0);
      chk("late_done", 64'({c_bdone, d_bdone, c_berr, d_berr}), 64'd0);
      chk("late_rdata", {c_rdata, d_rdata}, 64'd0);
      step();
      s_bdone = 1'b0;

      // completion in the last watchdog cycle counts as normal
      d_bstart = 1'b1;
      for (int k = 1; k <= TO; k++) begin
         step();
         s_bdone = (k == TO); s_rdata = 32'h0BAD_F00D;
         #1;
      end
      chk("to_edge_done", 64'({d_bdone, d_berr}), 64'b10);
      chk("to_edge_rdata", 64'(d_rdata), 64'h0BAD_F00D);
      step();
      d_bstart = 1'b0; s_bdone = 1'b0;

      // ---------------- reset mid-transfer ----------------
      d_bstart = 1'b1; d_addr = 32'h2000_0000; d_ttype = 1'b0;
      step();
      #1 chk("rmid_grant_before", 64'(grant), 64'b10);
      rst = 1'b1;
      #1;
      chk("rmid_grant", 64'(grant), 64'd0);
      chk("rmid_ctl", 64'({s_bstart, d_bdone, d_berr}), 64'd0);
      step(); step();
      rst = 1'b0;
      step();
      s_bdone = 1'b1; s_rdata = 32'hCAFE_F00D;
      #1;
      chk("rmid_reissue_grant", 64'(grant), 64'b10);
      chk("rmid_reissue_req", 64'({s_bstart, s_ttype, s_addr}), 64'({2'b10, 32'h2000_0000}));
      chk("rmid_reissue_done", 64'({d_bdone, d_berr, c_bdone}), 64'b100);
      chk("rmid_reissue_rdata", 64'(d_rdata), 64'hCAFE_F00D);
      step();
      d_bstart = 1'b0; s_bdone = 1'b0;

      // ---------------- randomized traffic against the reference model ----------------
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      m_owner = 0; m_streak = 0; m_wd = 0; cp = 1'b0; dp = 1'b0;
      e_cd = 1'b0; e_dd = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         step();
         // model advance at the edge just taken, using the inputs it sampled
         if (m_owner == 0) begin
            if (!c_bstart) m_streak = 0;
            if (c_bstart && d_bstart) nxt = (core_halted || m_streak < MAXS) ? 2 : 1;
            else if (d_bstart)       nxt = 2;
            else if (c_bstart)       nxt = 1;
            else                     nxt = 0;
            if (nxt == 2 && c_bstart && !core_halted && m_streak < MAXS) m_streak++;
            if (nxt == 1) m_streak = 0;
            m_owner = nxt; m_wd = 0;
         end else if (s_bdone || m_wd == TO - 1) begin
            m_owner = 0; m_wd = 0;
         end else begin
            m_wd++;
         end
         // masters hold requests until their own bdone, then maybe re-issue
         if (e_cd) cp = 1'b0;
         if (e_dd) dp = 1'b0;
         if (!cp && $urandom_range(2) == 0) begin
            cp = 1'b1; c_addr = $urandom; c_wdata = $urandom;
            c_ttype = 1'($urandom_range(1)); c_tsize = 2'($urandom_range(2));
         end
         if (!dp && $urandom_range(2) == 0) begin
            dp = 1'b1; d_addr = $urandom; d_wdata = $urandom;
            d_ttype = 1'($urandom_range(1)); d_tsize = 2'($urandom_range(2));
         end
         c_bstart = cp; d_bstart = dp;
         if ($urandom_range(24) == 0) core_halted = ~core_halted;
         s_bdone = ($urandom_range(9) < 3);
         s_rdata = $urandom;
         #1;
         to_e  = (m_owner != 0) && (m_wd == TO - 1) && !s_bdone;
         e_g   = (m_owner == 2) ? 2'b10 : (m_owner == 1) ? 2'b01 : 2'b00;
         e_cd  = (m_owner == 1) && (s_bdone || to_e);
         e_dd  = (m_owner == 2) && (s_bdone || to_e);
         e_ce  = (m_owner == 1) && to_e;
         e_de  = (m_owner == 2) && to_e;
         e_sbs = !to_e && ((m_owner == 1) ? c_bstart : (m_owner == 2) ? d_bstart : 1'b0);
         e_cr  = (m_owner == 1 && s_bdone) ? s_rdata : 32'h0;
         e_dr  = (m_owner == 2 && s_bdone) ? s_rdata : 32'h0;
         chk("rnd_grant", 64'(grant), 64'(e_g));
         chk("rnd_ctl", 64'({s_bstart, c_bdone, c_berr, d_bdone, d_berr}),
             64'({e_sbs, e_cd, e_ce, e_dd, e_de}));
         chk("rnd_rdata", {c_rdata, d_rdata}, {e_cr, e_dr});
         chk("rnd_req", 64'({s_ttype, s_tsize, s_addr}),
             (m_owner == 2) ? 64'({d_ttype, d_tsize, d_addr}) : 64'({c_ttype, c_tsize, c_addr}));
         chk("rnd_wdata", 64'(s_wdata), 64'((m_owner == 2) ? d_wdata : c_wdata));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
